sd_seq_check: RTL and testbench

SD_SEQ_CHECK -- requirements
Module: sd_seq_check

---
 rtl/sd_seq_check_if.sv | 9 +
 rtl/sd_seq_check.sv | 114 +++++++++++
 tb/tb_sd_seq_check.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/sd_seq_check_if.sv
// Producer/consumer valid-ready handshake carrying the incrementing data stream.
interface sd_seq_check_if #(parameter int width = 8);
  logic             c_srdy;
  logic             c_drdy;
  logic [width-1:0] c_data;

  modport master (output c_srdy, output c_data, input  c_drdy);
  modport slave  (input  c_srdy, input  c_data, output c_drdy);
endinterface

// File: rtl/sd_seq_check.sv
// Incrementing-sequence checker with a pattern-throttled registered drdy.
// state | meaning
// IDLE  | disabled, drdy low, pattern pointer parked at 0
// SYNC  | waiting for the first word to seed the expected value
// CHECK | comparing every accepted word against the expected value
module sd_seq_check #(
  parameter int width   = 8,
  parameter int pat_dep = 8
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  sd_seq_check_if.slave      s_if,
  input  logic               i_chk_en,
  input  logic               i_clear,
  input  logic [pat_dep-1:0] i_drdy_pat,
  output logic [15:0]        o_rx_count,
  output logic [15:0]        o_err_count,
  output logic               o_err,
  output logic [width-1:0]   o_err_data
);
  localparam int PW = (pat_dep > 1) ? $clog2(pat_dep) : 1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SYNC  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  logic [1:0]       r_rst_sync;
  logic             w_rst_n;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    w_ptr_nxt;
  logic             r_drdy;
  logic [width-1:0] r_expected;
  logic [15:0]      r_rx_count;
  logic [15:0]      r_err_count;
  logic             r_err;
  logic [width-1:0] r_err_data;
  logic             w_xfer;
  logic             w_active;

  // Assert asynchronously, release two edges later so all state leaves reset together.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_rst_sync <= 2'b00;
    else            r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_xfer   = s_if.c_srdy & r_drdy;
  assign w_active = (r_state == ST_SYNC) || (r_state == ST_CHECK);

  always_comb begin
    w_state_nxt = r_state;
    if (!i_chk_en) begin
      w_state_nxt = ST_IDLE;
    end else if (i_clear) begin
      w_state_nxt = ST_SYNC;
    end else begin
      case (r_state)
        ST_IDLE:  w_state_nxt = ST_SYNC;
        ST_SYNC:  if (w_xfer) w_state_nxt = ST_CHECK;
        ST_CHECK: w_state_nxt = ST_CHECK;
        default:  w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // drdy is registered from the slot the pointer moves into, so c_drdy in slot k is pattern bit k.
  always_comb begin
    w_ptr_nxt = '0;
    if (!i_clear && w_active && (w_state_nxt != ST_IDLE)) begin
      if (r_ptr == PW'(pat_dep - 1)) w_ptr_nxt = '0;
      else                           w_ptr_nxt = r_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_drdy      <= 1'b0;
      r_expected  <= '0;
      r_rx_count  <= '0;
      r_err_count <= '0;
      r_err       <= 1'b0;
      r_err_data  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_drdy  <= (w_state_nxt != ST_IDLE) ? i_drdy_pat[w_ptr_nxt] : 1'b0;
      if (i_clear) begin
        r_expected  <= '0;
        r_rx_count  <= '0;
        r_err_count <= '0;
        r_err       <= 1'b0;
        r_err_data  <= '0;
      end else if (w_xfer && w_active) begin
        // Match or mismatch, the next expected word follows the one just received.
        r_expected <= s_if.c_data + 1'b1;
        if (r_rx_count != 16'hFFFF) r_rx_count <= r_rx_count + 16'd1;
        if ((r_state == ST_CHECK) && (s_if.c_data != r_expected)) begin
          if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
          r_err      <= 1'b1;
          r_err_data <= s_if.c_data;
        end
      end
    end
  end

  assign s_if.c_drdy = r_drdy;
  assign o_rx_count  = r_rx_count;
  assign o_err_count = r_err_count;
  assign o_err       = r_err;
  assign o_err_data  = r_err_data;
endmodule

// File: tb/tb_sd_seq_check.sv
// Directed bench for sd_seq_check: streams, wrap, gaps, throttling, clear and reset.
module tb_sd_seq_check;
  logic        clk;
  logic        reset_n;
  logic        chk_en;
  logic        clear;
  logic [7:0]  drdy_pat;
  logic [15:0] rx_count;
  logic [15:0] err_count;
  logic        err;
  logic [7:0]  err_data;
  int          nvec;
  int          nmis;

  sd_seq_check_if #(.width(8)) bus ();

  sd_seq_check #(.width(8), .pat_dep(8)) dut (
    .i_clk       (clk),
    .i_reset_n   (reset_n),
    .s_if        (bus),
    .i_chk_en    (chk_en),
    .i_clear     (clear),
    .i_drdy_pat  (drdy_pat),
    .o_rx_count  (rx_count),
    .o_err_count (err_count),
    .o_err       (err),
    .o_err_data  (err_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offer one word and return #1 after the edge that accepts it; srdy is left high.
  task automatic send(input logic [7:0] d);
    logic done;
    done = 1'b0;
    bus.c_srdy = 1'b1;
    bus.c_data = d;
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clk);
      if (bus.c_drdy) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    chk("send_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic idle_cycles(input int n);
    bus.c_srdy = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_clear();
    bus.c_srdy = 1'b0;
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  initial begin
    logic [3:0] dr;
    nvec = 0;
    nmis = 0;
    reset_n = 1'b1;
    chk_en = 1'b0;
    clear = 1'b0;
    drdy_pat = 8'hFF;
    bus.c_srdy = 1'b0;
    bus.c_data = 8'h00;
    #3 reset_n = 1'b0;

    // Reset: outputs quiet even with activity on the inputs.
    @(posedge clk); #1;
    chk_en = 1'b1;
    bus.c_srdy = 1'b1;
    bus.c_data = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_drdy", {31'd0, bus.c_drdy}, 32'd0);
    end
    chk("rst_rx", {16'd0, rx_count}, 32'd0);
    chk("rst_errc", {16'd0, err_count}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_errd", {24'd0, err_data}, 32'd0);
    @(posedge clk); #1;
    chk_en = 1'b0;
    bus.c_srdy = 1'b0;
    reset_n = 1'b1;
    idle_cycles(4);
    @(negedge clk);
    chk("idle_drdy", {31'd0, bus.c_drdy}, 32'd0);
    @(posedge clk); #1;

    // Continuous stream 0x00..0x13.
    chk_en = 1'b1;
    for (int i = 0; i < 20; i++) send(8'(i));
    idle_cycles(2);
    chk("t1_rx", {16'd0, rx_count}, 32'd20);
    chk("t1_errc", {16'd0, err_count}, 32'd0);
    chk("t1_err", {31'd0, err}, 32'd0);
    @(negedge clk);
    chk("t1_drdy_on", {31'd0, bus.c_drdy}, 32'd1);
    @(posedge clk); #1;

    // Wrap from 0xFF to 0x00 is a match.
    pulse_clear();
    chk("t2_clr_rx", {16'd0, rx_count}, 32'd0);
    send(8'hFD); send(8'hFE); send(8'hFF); send(8'h00); send(8'h01);
    idle_cycles(1);
    chk("t2_rx", {16'd0, rx_count}, 32'd5);
    chk("t2_errc", {16'd0, err_count}, 32'd0);

    // One dropped word counts once, then the stream resyncs.
    pulse_clear();
    send(8'h10); send(8'h11); send(8'h13); send(8'h14);
    idle_cycles(1);
    chk("t3_errc", {16'd0, err_count}, 32'd1);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_errd", {24'd0, err_data}, 32'h13);
    chk("t3_rx", {16'd0, rx_count}, 32'd4);
    idle_cycles(3);
    send(8'h15);
    idle_cycles(1);
    chk("t3_gap_errc", {16'd0, err_count}, 32'd1);

    // Disable mid-stream keeps counters; re-enable resyncs.
    chk_en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t4_dis_drdy", {31'd0, bus.c_drdy}, 32'd0);
    idle_cycles(2);
    chk("t4_dis_rx", {16'd0, rx_count}, 32'd5);
    chk("t4_dis_err", {31'd0, err}, 32'd1);
    chk_en = 1'b1;
    send(8'h80); send(8'h81);
    idle_cycles(1);
    chk("t4_rx", {16'd0, rx_count}, 32'd7);
    chk("t4_errc", {16'd0, err_count}, 32'd1);

    // Alternating throttle pattern.
    drdy_pat = 8'b0101_0101;
    pulse_clear();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      dr[k] = bus.c_drdy;
    end
    @(posedge clk); #1;
    chk("t5_alt01", {31'd0, dr[0] ^ dr[1]}, 32'd1);
    chk("t5_alt12", {31'd0, dr[1] ^ dr[2]}, 32'd1);
    chk("t5_alt23", {31'd0, dr[2] ^ dr[3]}, 32'd1);
    for (int i = 0; i < 16; i++) send(8'h30 + 8'(i));
    idle_cycles(1);
    chk("t5_rx", {16'd0, rx_count}, 32'd16);
    chk("t5_errc", {16'd0, err_count}, 32'd0);

    // Clear coincident with a transfer: the word is swallowed, next word is SYNC.
    drdy_pat = 8'hFF;
    pulse_clear();
    for (int i = 0; i < 5; i++) send(8'h50 + 8'(i));
    chk("t6_rx5", {16'd0, rx_count}, 32'd5);
    clear = 1'b1;
    bus.c_data = 8'h99;
    @(negedge clk);
    chk("t6_coinc_drdy", {31'd0, bus.c_drdy}, 32'd1);
    @(posedge clk); #1;
    clear = 1'b0;
    bus.c_srdy = 1'b0;
    chk("t6_rx0", {16'd0, rx_count}, 32'd0);
    chk("t6_err0", {31'd0, err}, 32'd0);
    send(8'h77);
    idle_cycles(1);
    chk("t6_sync_rx", {16'd0, rx_count}, 32'd1);
    chk("t6_sync_err", {31'd0, err}, 32'd0);
    send(8'h78);
    idle_cycles(1);
    chk("t6_errc", {16'd0, err_count}, 32'd0);

    // Reset in the middle of a stream, then resume at 0x40.
    pulse_clear();
    send(8'h20); send(8'h21); send(8'h23); send(8'h24); send(8'h25);
    chk("t7_pre_rx", {16'd0, rx_count}, 32'd5);
    chk("t7_pre_errc", {16'd0, err_count}, 32'd1);
    bus.c_data = 8'h26;
    reset_n = 1'b0;
    #1;
    chk("t7_rst_rx", {16'd0, rx_count}, 32'd0);
    chk("t7_rst_errc", {16'd0, err_count}, 32'd0);
    chk("t7_rst_err", {31'd0, err}, 32'd0);
    chk("t7_rst_errd", {24'd0, err_data}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      bus.c_data = 8'h27 + 8'(k);
      @(negedge clk);
      chk("t7_rst_drdy", {31'd0, bus.c_drdy}, 32'd0);
    end
    @(posedge clk); #1;
    bus.c_srdy = 1'b0;
    reset_n = 1'b1;
    send(8'h40);
    idle_cycles(1);
    chk("t7_rx1", {16'd0, rx_count}, 32'd1);
    for (int i = 1; i < 8; i++) send(8'h40 + 8'(i));
    idle_cycles(1);
    chk("t7_rx", {16'd0, rx_count}, 32'd8);
    chk("t7_errc", {16'd0, err_count}, 32'd0);
    chk("t7_err", {31'd0, err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end
endmodule
